coeff_token_flc_decoder: RTL and testbench



---
 rtl/cavlc_pkg.sv | 22 ++
 rtl/coeff_token_flc_map.sv | 37 +++
 rtl/coeff_token_flc_decoder.sv | 106 ++++++++++
 tb/tb_coeff_token_flc_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cavlc_pkg.sv
// ============================================================================
// cavlc_pkg : shared CAVLC coeff_token constants, token format and FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package cavlc_pkg;

  localparam int          CT_FLC_LEN   = 6;
  localparam logic [5:0]  CT_ZERO_CODE = 6'b000011;
  localparam int          T1S_W        = 2;
  localparam int          TC_W         = 5;
  localparam int          TOK_W        = T1S_W + TC_W;

  typedef enum logic [0:0] {
    ST_SHIFT = 1'b0,
    ST_HOLD  = 1'b1
  } ct_state_t;

endpackage

`default_nettype wire

// File: rtl/coeff_token_flc_map.sv
// ============================================================================
// coeff_token_flc_map : maps a 6-bit nC>=8 coeff_token code to {err,t1s,total}
// Rev 1.0
// ============================================================================
`default_nettype none

module coeff_token_flc_map
  import cavlc_pkg::*;
(
  input  logic [CT_FLC_LEN-1:0] code_i,
  output logic                  err_o,
  output logic [T1S_W-1:0]      t1s_o,
  output logic [TC_W-1:0]       total_o
);

  logic [TC_W-1:0] total_raw;

  assign total_raw = {1'b0, code_i[5:2]} + 5'd1;

  always_comb begin
    err_o   = 1'b0;
    t1s_o   = code_i[1:0];
    total_o = total_raw;
    if (code_i == CT_ZERO_CODE) begin
      t1s_o   = '0;
      total_o = '0;
    end else if ({3'b000, code_i[1:0]} > total_raw) begin
      // Only 000010 and 000111 land here: trailing ones exceed the coefficient count.
      err_o   = 1'b1;
      t1s_o   = '0;
      total_o = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/coeff_token_flc_decoder.sv
// ============================================================================
// coeff_token_flc_decoder : serial-in FLC coeff_token decoder (nC >= 8)
// Rev 1.0
// ============================================================================
`default_nettype none

module coeff_token_flc_decoder
  import cavlc_pkg::*;
#(
  parameter int aWIDTH   = 7,
  parameter int CODE_LEN = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [aWIDTH-1:0] tok_addr,
  output logic [TC_W-1:0]   tok_total,
  output logic [T1S_W-1:0]  tok_t1s,
  output logic              tok_err,
  output logic              tok_valid,
  input  logic              tok_ready
);

  ct_state_t             state_q;
  logic [2:0]            bit_cnt_q;
  logic [CT_FLC_LEN-1:0] shift_q;
  logic [CT_FLC_LEN-1:0] shift_d;
  logic                  bit_ready_q;
  logic                  tok_valid_q;
  logic                  tok_err_q;
  logic [T1S_W-1:0]      tok_t1s_q;
  logic [TC_W-1:0]       tok_total_q;

  logic                  map_err;
  logic [T1S_W-1:0]      map_t1s;
  logic [TC_W-1:0]       map_total;

  assign shift_d = {shift_q[CT_FLC_LEN-2:0], bit_in};

  coeff_token_flc_map u_map (
    .code_i  (shift_d),
    .err_o   (map_err),
    .t1s_o   (map_t1s),
    .total_o (map_total)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SHIFT;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      bit_ready_q <= 1'b1;
      tok_valid_q <= 1'b0;
      tok_err_q   <= 1'b0;
      tok_t1s_q   <= '0;
      tok_total_q <= '0;
    end else if (flush) begin
      state_q     <= ST_SHIFT;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      bit_ready_q <= 1'b1;
      tok_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (bit_valid) begin
            shift_q <= shift_d;
            if (bit_cnt_q == 3'(CODE_LEN - 1)) begin
              bit_cnt_q   <= '0;
              state_q     <= ST_HOLD;
              bit_ready_q <= 1'b0;
              tok_valid_q <= 1'b1;
              tok_err_q   <= map_err;
              tok_t1s_q   <= map_t1s;
              tok_total_q <= map_total;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        ST_HOLD: begin
          // bit_ready stays low in the accept cycle, so a new bit can only follow a cycle later.
          if (tok_ready) begin
            state_q     <= ST_SHIFT;
            bit_ready_q <= 1'b1;
            tok_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_SHIFT;
      endcase
    end
  end

  assign bit_ready = bit_ready_q & ~flush;
  assign tok_valid = tok_valid_q;
  assign tok_err   = tok_err_q;
  assign tok_t1s   = tok_t1s_q;
  assign tok_total = tok_total_q;
  assign tok_addr  = aWIDTH'({tok_t1s_q, tok_total_q});

endmodule

`default_nettype wire

// File: tb/tb_coeff_token_flc_decoder.sv
// ============================================================================
// tb_coeff_token_flc_decoder : scoreboard bench for the FLC coeff_token decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_coeff_token_flc_decoder;

  typedef struct packed {
    logic       err;
    logic [1:0] t1s;
    logic [4:0] total;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [6:0] tok_addr;
  logic [4:0] tok_total;
  logic [1:0] tok_t1s;
  logic       tok_err;
  logic       tok_valid;
  logic       tok_ready;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  coeff_token_flc_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .tok_addr  (tok_addr),
    .tok_total (tok_total),
    .tok_t1s   (tok_t1s),
    .tok_err   (tok_err),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per accepted token.
  always @(negedge clk) begin
    if (rst_n && tok_valid && tok_ready) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_token: got addr %0h with empty scoreboard", tok_addr);
      end else begin
        e = sb_q.pop_front();
        check("tok_total", 32'(tok_total), 32'(e.total));
        check("tok_t1s",   32'(tok_t1s),   32'(e.t1s));
        check("tok_err",   32'(tok_err),   32'(e.err));
        check("tok_addr",  32'(tok_addr),  32'({e.t1s, e.total}));
      end
    end
  end

  task automatic send_bit(input logic b, input int gap_max);
    int n;
    bit_valid = 1'b0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
    n = 0;
    while (!bit_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bit_ready) begin
      checks++;
      errors++;
      $display("FAIL bit_handshake_timeout: bit_ready 0 expected 1");
    end
    @(posedge clk);
    #1 bit_valid = 1'b0;
  endtask

  // Sends a 6-bit code; returns on the negedge after the 6th handshake.
  task automatic send_code(input logic [5:0] c, input int gap_max, input logic push,
                           input logic [1:0] t1s, input logic [4:0] total, input logic err);
    exp_t e;
    if (push) begin
      e.err = err; e.t1s = t1s; e.total = total;
      sb_q.push_back(e);
    end
    for (int i = 5; i >= 0; i--) send_bit(c[i], gap_max);
    @(negedge clk);
    check("latency_tok_valid", 32'(tok_valid), 32'd1);
    check("hold_bit_ready",    32'(bit_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; tok_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bit_ready", 32'(bit_ready), 32'd1);
    check("rst_tok_valid", 32'(tok_valid), 32'd0);
    check("rst_tok_addr",  32'(tok_addr),  32'd0);
    check("rst_tok_err",   32'(tok_err),   32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Zero-coefficient code
    send_code(6'b000011, 0, 1'b1, 2'd0, 5'd0, 1'b0);
    // Back-to-back extremes, bit_ready low exactly one cycle between them
    send_code(6'b000000, 0, 1'b1, 2'd0, 5'd1, 1'b0);
    @(negedge clk);
    check("gap_bit_ready", 32'(bit_ready), 32'd1);
    send_code(6'b111111, 0, 1'b1, 2'd3, 5'd16, 1'b0);
    // Illegal codes, then a legal one
    send_code(6'b000010, 0, 1'b1, 2'd0, 5'd0, 1'b1);
    send_code(6'b000111, 0, 1'b1, 2'd0, 5'd0, 1'b1);
    send_code(6'b000101, 0, 1'b1, 2'd1, 5'd2, 1'b0);

    // Consumer stall: token stays stable, offered bits are refused
    @(posedge clk); #1 tok_ready = 1'b0;
    send_code(6'b001011, 0, 1'b1, 2'd3, 5'd3, 1'b0);
    bit_valid = 1'b1; bit_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_tok_valid", 32'(tok_valid), 32'd1);
      check("stall_bit_ready", 32'(bit_ready), 32'd0);
      check("stall_tok_addr",  32'(tok_addr),  32'h63);
    end
    bit_valid = 1'b0;
    @(posedge clk); #1 tok_ready = 1'b1;
    send_code(6'b000101, 0, 1'b1, 2'd1, 5'd2, 1'b0);

    // Flush discards a partial code
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    @(negedge clk);
    flush = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    #1 check("flush_bit_ready", 32'(bit_ready), 32'd0);
    @(posedge clk); #1 flush = 1'b0; bit_valid = 1'b0;
    send_code(6'b000001, 0, 1'b1, 2'd1, 5'd1, 1'b0);

    // Asynchronous reset mid-code
    @(negedge clk);
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("midcode_rst_bit_ready", 32'(bit_ready), 32'd1);
    check("midcode_rst_tok_valid", 32'(tok_valid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Asynchronous reset mid-HOLD
    tok_ready = 1'b0;
    send_code(6'b111111, 0, 1'b0, 2'd0, 5'd0, 1'b0);
    check("hold_tok_addr", 32'(tok_addr), 32'h70);
    #2 rst_n = 1'b0;
    #1;
    check("midhold_rst_tok_valid", 32'(tok_valid), 32'd0);
    check("midhold_rst_tok_addr",  32'(tok_addr),  32'd0);
    check("midhold_rst_bit_ready", 32'(bit_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1; tok_ready = 1'b1;

    // Loopback over every legal (total, t1s) pair with random bit gaps
    for (int tot = 0; tot <= 16; tot++) begin
      for (int t = 0; t <= 3; t++) begin
        if (t <= tot) begin
          logic [5:0] code;
          logic [4:0] tm1;
          tm1  = 5'(tot - 1);
          code = (tot == 0) ? 6'b000011 : {tm1[3:0], 2'(t)};
          send_code(code, 2, 1'b1, 2'(t), 5'(tot), 1'b0);
        end
      end
    end

    begin
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
